dct_arb: RTL and testbench

- Two-port round-robin arbiter and sequencer that shares one dct_top engine between two requesters, for example a row pass and a column pass.
- Latches the winning requester's vector and size, drives the engine start/ready handshake, and captures the result.
- Returns a per-requester done or err pulse.
- Sits between the requesters and the single dct_top instance; there is no combinational path from requester inputs to engine outputs.

---
 rtl/dct_arb.sv | 111 +++++++++++
 tb/tb_dct_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_arb.sv
// dct_arb: two-port round-robin arbiter/sequencer in front of a single dct_top
// engine. The winning requester's size and vector are registered, the engine
// start/ready handshake is driven from the registered copy, and the result is
// captured with a one-cycle done (or err) pulse back to the owner.
module dct_arb #(
   parameter int M       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req,
   input  logic [3:0]      num0,
   input  logic [3:0]      num1,
   input  logic [M*16-1:0] data0,
   input  logic [M*16-1:0] data1,
   output logic [1:0]      done,
   output logic [1:0]      err,
   output logic [M*16-1:0] res,
   output logic            busy,
   output logic            eng_start,
   output logic [3:0]      eng_number,
   output logic [M*16-1:0] eng_data,
   input  logic            eng_ready,
   input  logic [M*16-1:0] eng_out
);

   localparam int W  = M * 16;
   localparam int CW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [3:0]    MIN_NUM  = 4'd7;

   logic [1:0]    state;
   logic          rr;
   logic          owner;
   logic [CW-1:0] cnt;

   logic          win;
   logic [3:0]    win_num;
   logic [W-1:0]  win_data;

   // Round-robin pick: the pointed-to requester if it is asking, else the other
   assign win      = req[rr] ? rr : ~rr;
   assign win_num  = win ? num1 : num0;
   assign win_data = win ? data1 : data0;

   assign busy = (state != IDLE);

   // Arbitration, engine handshake, timeout and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr         <= 1'b0;
         owner      <= 1'b0;
         cnt        <= '0;
         done       <= '0;
         err        <= '0;
         res        <= '0;
         eng_start  <= 1'b0;
         eng_number <= '0;
         eng_data   <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  // Latch happens even for a bad size; the pointer advances
                  // either way so an erroring requester cannot starve the other.
                  eng_number <= win_num;
                  eng_data   <= win_data;
                  owner      <= win;
                  rr         <= ~win;
                  if (win_num >= MIN_NUM) begin
                     eng_start <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     err[win] <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               cnt <= cnt + CW'(1);
               if (eng_ready) begin
                  res         <= eng_out;
                  done[owner] <= 1'b1;
                  eng_start   <= 1'b0;
                  state       <= RELEASE;
               end else if (cnt == CNT_LAST) begin
                  eng_start  <= 1'b0;
                  err[owner] <= 1'b1;
                  state      <= RELEASE;
               end
            end
            RELEASE: begin
               // Wait for the engine to drop ready before any new grant
               if (!eng_ready) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dct_arb.sv
// Directed bench for dct_arb with a behavioural engine model and a scoreboard
// monitor that checks grants and done/err responses against queued expectations.
module tb_dct_arb;

   localparam int M  = 32;
   localparam int W  = M * 16;
   localparam int TO = 16;
   localparam logic [W-1:0] PAT = {16{32'hA5A5A5A5}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req;
   logic [3:0]   num0, num1;
   logic [W-1:0] data0, data1;
   logic [1:0]   done, err;
   logic [W-1:0] res;
   logic         busy, eng_start;
   logic [3:0]   eng_number;
   logic [W-1:0] eng_data;
   logic         eng_ready;
   logic [W-1:0] eng_out;

   dct_arb #(.M(M), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .num0(num0), .num1(num1),
      .data0(data0), .data1(data1), .done(done), .err(err), .res(res),
      .busy(busy), .eng_start(eng_start), .eng_number(eng_number),
      .eng_data(eng_data), .eng_ready(eng_ready), .eng_out(eng_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic hang;
   logic [7:0] ecnt;
   logic start_q;

   typedef struct {logic is_err; logic id; logic [W-1:0] res;} resp_t;
   typedef struct {logic [3:0] num; logic [W-1:0] data;} grant_t;
   resp_t  resp_q[$];
   grant_t grant_q[$];

   function automatic logic [W-1:0] mkvec(input int base, input int n);
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < 16; k++)
         if (k < n) v[k*M +: M] = M'(base + k + 1);
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_grant(input logic [3:0] n, input logic [W-1:0] d);
      grant_t g;
      g.num = n; g.data = d;
      grant_q.push_back(g);
   endtask

   task automatic exp_resp(input logic is_err, input logic id, input logic [W-1:0] r);
      resp_t e;
      e.is_err = is_err; e.id = id; e.res = r;
      resp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel: 0 start high, 1 start low, 2 done|err, 3 ready high, 4 ready low, 5 idle
   task automatic wait_for(input int sel, input int lim, input string name);
      int n;
      logic hit;
      n = 0;
      forever begin
         case (sel)
            0: hit = eng_start;
            1: hit = !eng_start;
            2: hit = ((done | err) != 2'b00);
            3: hit = eng_ready;
            4: hit = !eng_ready;
            default: hit = !busy;
         endcase
         if (hit) break;
         if (n >= lim) begin
            checks++; errors++;
            $display("FAIL %s: timed out after %0d cycles, required event %0d", name, n, sel);
            break;
         end
         tick();
         n++;
      end
   endtask

   // Engine model: ready 4 cycles after start, output = data ^ PAT, drops after start falls
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_ready <= 1'b0;
         eng_out   <= '0;
         ecnt      <= '0;
      end else if (eng_start && !eng_ready) begin
         if (!hang && ecnt == 8'd3) begin
            eng_ready <= 1'b1;
            eng_out   <= eng_data ^ PAT;
            ecnt      <= '0;
         end else begin
            ecnt <= ecnt + 8'd1;
         end
      end else if (!eng_start) begin
         eng_ready <= 1'b0;
         ecnt      <= '0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: checks each grant and each done/err pulse in order
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         start_q = 1'b0;
      end else begin
         if (eng_start && !start_q) begin
            if (grant_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL grant_unexp: got start num=%0d, required no start", eng_number);
            end else begin
               grant_t g;
               g = grant_q.pop_front();
               check("grant_num", W'(eng_number), W'(g.num));
               check("grant_data", eng_data, g.data);
            end
         end
         if ((done | err) != 2'b00) begin
            check("done_err_excl", W'(done & err), '0);
            if (resp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL resp_unexp: got done=%b err=%b, required none", done, err);
            end else begin
               resp_t e;
               logic [1:0] vec;
               e = resp_q.pop_front();
               vec = e.id ? 2'b10 : 2'b01;
               check("resp_done", W'(done), e.is_err ? '0 : W'(vec));
               check("resp_err", W'(err), e.is_err ? W'(vec) : '0);
               if (!e.is_err) check("resp_res", res, e.res);
            end
         end
         start_q = eng_start;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      int t0;
      logic [W-1:0] da;
      rst_n = 1'b0; req = '0; num0 = '0; num1 = '0;
      data0 = '0; data1 = '0; hang = 1'b0;
      #12;
      check("rst_ctl", W'({done, err, busy, eng_start, eng_number}), '0);
      check("rst_res", res, '0);
      check("rst_edata", eng_data, '0);
      @(negedge clk) rst_n = 1'b1;
      tick(); tick();

      // Single request, size 7
      num0 = 4'd7; data0 = mkvec(0, 8);
      exp_grant(4'd7, data0);
      exp_resp(1'b0, 1'b0, data0 ^ PAT);
      req = 2'b01;
      tick();
      check("start_lat", W'(eng_start), W'(1));
      wait_for(3, 20, "single_ready");
      tick();
      check("done_lat", W'(done), W'(2'b01));
      req = 2'b00;
      wait_for(4, 20, "single_rdy_low");
      tick();
      check("busy_idle", W'(busy), '0);

      // Invalid size from requester 1
      num1 = 4'd3; data1 = mkvec(256, 16);
      exp_resp(1'b1, 1'b1, '0);
      req = 2'b10;
      tick();
      check("err_lat", W'(err), W'(2'b10));
      req = 2'b00;
      tick();
      check("inv_nostart", W'({eng_start, busy}), '0);

      // Contention: both held, grants must go 0,1,0,1
      num0 = 4'd8; data0 = mkvec(0, 8);
      num1 = 4'd15; data1 = mkvec(256, 16);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            exp_grant(4'd8, data0); exp_resp(1'b0, 1'b0, data0 ^ PAT);
         end else begin
            exp_grant(4'd15, data1); exp_resp(1'b0, 1'b1, data1 ^ PAT);
         end
      end
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_for(2, 40, "cont_done");
         check("cont_owner", W'(done), (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
         if (i == 3) req = 2'b00;
         tick();
      end
      wait_for(5, 20, "cont_idle");

      // Timeout: engine never answers
      hang = 1'b1;
      num0 = 4'd9; data0 = mkvec(16, 16);
      exp_grant(4'd9, data0);
      exp_resp(1'b1, 1'b0, '0);
      req = 2'b01;
      wait_for(0, 5, "to_start");
      t0 = cyc;
      wait_for(1, 40, "to_fall");
      check("to_len", W'(cyc - t0), W'(TO));
      check("to_err", W'(err), W'(2'b01));
      req = 2'b00;
      tick(); tick();
      check("to_idle", W'(busy), '0);
      hang = 1'b0;

      // Requester changes inputs and drops req mid-operation
      da = mkvec(32, 16);
      num0 = 4'd10; data0 = da;
      exp_grant(4'd10, da);
      exp_resp(1'b0, 1'b0, da ^ PAT);
      req = 2'b01;
      wait_for(0, 5, "mid_start");
      tick();
      data0 = mkvec(64, 16); num0 = 4'd3; req = 2'b00;
      tick();
      check("mid_data", eng_data, da);
      check("mid_num", W'(eng_number), W'(10));
      wait_for(2, 20, "mid_done");
      check("mid_done", W'(done), W'(2'b01));
      wait_for(5, 20, "mid_idle");

      // Reset in the middle of ISSUE
      num0 = 4'd12; data0 = mkvec(48, 16);
      exp_grant(4'd12, data0);
      req = 2'b01;
      wait_for(0, 5, "rst_start");
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl", W'({done, err, busy, eng_start, eng_number}), '0);
      check("arst_res", res, '0);
      check("arst_edata", eng_data, '0);
      req = 2'b00;
      @(negedge clk) rst_n = 1'b1;
      tick(); tick();
      exp_grant(4'd12, data0);
      exp_resp(1'b0, 1'b0, data0 ^ PAT);
      req = 2'b01;
      wait_for(2, 30, "post_rst_done");
      check("post_rst_done", W'(done), W'(2'b01));
      req = 2'b00;
      wait_for(5, 20, "post_rst_idle");
      tick(); tick();

      check("queues_empty", W'(resp_q.size() + grant_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
